// File: rtl/rv_pack_pkg.sv
// Shared defaults and types for the byte packer.
package rv_pack_pkg;

  localparam int unsigned PACK_DATA_WIDTH = 8;
  localparam int unsigned PACK_LANES      = 4;
  localparam int unsigned PACK_FILL_W     = (PACK_LANES > 1) ? $clog2(PACK_LANES) : 1;

  typedef logic [PACK_LANES-1:0]  keep_t;
  typedef logic [PACK_FILL_W-1:0] fill_t;

endpackage

// File: rtl/rv_byte_packer.sv
// Packs a stream of bytes into LANES-wide words with keep mask and last flag.
// A word closes when the top lane fills or a byte arrives flagged last; the
// output register is reloaded in the same cycle it is drained, so a full
// stream runs at one byte per clock when downstream is always ready.
module rv_byte_packer
  import rv_pack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PACK_DATA_WIDTH,
  parameter int unsigned LANES      = PACK_LANES
) (
  input  logic                          clock_port,
  input  logic                          reset_port,
  input  logic [DATA_WIDTH-1:0]         input_port_data,
  input  logic                          input_port_valid,
  input  logic                          input_port_last,
  output logic                          input_port_ready,
  output logic [DATA_WIDTH*LANES-1:0]   output_port_data,
  output logic [LANES-1:0]              output_port_keep,
  output logic                          output_port_last,
  output logic                          output_port_valid,
  input  logic                          output_port_ready
);

  localparam int unsigned FILL_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WORD_W = DATA_WIDTH * LANES;
  localparam logic [FILL_W-1:0] LAST_LANE = FILL_W'(LANES - 1);

  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]  out_keep_q, out_keep_d;
  logic              out_last_q, out_last_d;
  logic              out_valid_q, out_valid_d;

  logic              in_ready;
  logic              in_fire;
  logic              complete;
  logic [WORD_W-1:0] word;
  logic [LANES-1:0]  keep;

  // Ready only depends on whether the output register is free or draining.
  assign in_ready = reset_port & (~out_valid_q | output_port_ready);

  // Merge the incoming byte into the accumulator and decide word completion.
  always_comb begin
    fill_d      = fill_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    word        = acc_q;
    keep        = '0;

    in_fire  = input_port_valid & in_ready;
    complete = in_fire & (input_port_last | (fill_q == LAST_LANE));

    for (int i = 0; i < LANES; i++) begin
      if (FILL_W'(i) == fill_q) word[i*DATA_WIDTH +: DATA_WIDTH] = input_port_data;
      keep[i] = (FILL_W'(i) <= fill_q);
    end

    if (out_valid_q & output_port_ready) out_valid_d = 1'b0;

    if (in_fire) begin
      if (complete) begin
        // Unfilled lanes are already zero because the accumulator clears on every completion.
        fill_d      = '0;
        acc_d       = '0;
        out_data_d  = word;
        out_keep_d  = keep;
        out_last_d  = input_port_last;
        out_valid_d = 1'b1;
      end else begin
        fill_d = fill_q + FILL_W'(1);
        acc_d  = word;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock_port) begin
    if (!reset_port) begin
      fill_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Outputs read as zero for the whole time reset is held, not just after its first edge.
  assign input_port_ready  = in_ready;
  assign output_port_data  = reset_port ? out_data_q : '0;
  assign output_port_keep  = reset_port ? out_keep_q : '0;
  assign output_port_last  = reset_port & out_last_q;
  assign output_port_valid = reset_port & out_valid_q;

endmodule

// File: tb/tb_rv_byte_packer.sv
// Self-checking bench for rv_byte_packer: directed scenarios plus random traffic
// compared against a byte-list reference model.
module tb_rv_byte_packer;
  import rv_pack_pkg::*;

  localparam int LN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  rv_byte_packer #(.DATA_WIDTH(8), .LANES(LN)) dut (
    .clock_port        (clk),
    .reset_port        (rst_n),
    .input_port_data   (in_data),
    .input_port_valid  (in_valid),
    .input_port_last   (in_last),
    .input_port_ready  (in_ready),
    .output_port_data  (out_data),
    .output_port_keep  (out_keep),
    .output_port_last  (out_last),
    .output_port_valid (out_valid),
    .output_port_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: accepted bytes of the open word, plus the pending output word.
  logic [7:0]  cur[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [3:0]  m_keep  = '0;
  logic        m_last  = 1'b0;
  int          words_out = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // One clock: drive at negedge, check, then advance the model on the rising edge.
  task automatic step(input logic v, input logic [7:0] d, input logic l,
                      input logic ordy, output logic fired);
    logic exp_rdy;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = ordy;
    #1;
    exp_rdy = rst_n && (!m_valid || ordy);
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    check("out_valid", {31'b0, out_valid}, {31'b0, rst_n && m_valid});
    if (rst_n && m_valid) begin
      check("out_data", out_data, m_data);
      check("out_keep", {28'b0, out_keep}, {28'b0, m_keep});
      check("out_last", {31'b0, out_last}, {31'b0, m_last});
    end else if (!rst_n) begin
      check("rst_data", out_data, 32'h0);
      check("rst_keep", {28'b0, out_keep}, 32'h0);
      check("rst_last", {31'b0, out_last}, 32'h0);
    end
    fired = v && exp_rdy;
    @(posedge clk);
    if (!rst_n) begin
      cur.delete();
      m_valid = 1'b0;
    end else begin
      if (m_valid && ordy) begin
        words_out++;
        m_valid = 1'b0;
      end
      if (fired) begin
        cur.push_back(d);
        if (cur.size() == LN || l) begin
          m_data = '0;
          m_keep = '0;
          foreach (cur[i]) begin
            m_data[i*8 +: 8] = cur[i];
            m_keep[i]        = 1'b1;
          end
          m_last  = l;
          m_valid = 1'b1;
          cur.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    logic f;
    step(1'b0, 8'h00, 1'b0, ordy, f);
  endtask

  // Present a byte until it is taken, with a bounded retry budget.
  task automatic send(input logic [7:0] d, input logic l, input logic ordy);
    logic f;
    for (int t = 0; t < 50; t++) begin
      step(1'b1, d, l, ordy, f);
      if (f) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w0;
    logic f;
    in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
    rst_n = 1'b0;
    @(negedge clk);
    repeat (3) idle(1'b0);
    rst_n = 1'b1;
    idle(1'b1);

    // Four bytes back to back, closing on the fourth.
    send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h33, 0, 1);
    check("w31_pre_valid", {31'b0, out_valid}, 32'd0);
    send(8'h44, 1, 1);
    check("w31_data", out_data, 32'h44332211);
    check("w31_keep", {28'b0, out_keep}, 32'hF);
    check("w31_last", {31'b0, out_last}, 32'd1);
    idle(1'b1);

    // Short packet, then a fresh byte must restart at lane 0.
    send(8'hAA, 0, 1); send(8'hBB, 1, 1);
    check("w32_data", out_data, 32'h0000BBAA);
    check("w32_keep", {28'b0, out_keep}, 32'h3);
    send(8'hCC, 1, 1);
    check("w32_next", out_data, 32'h000000CC);
    check("w32_nkeep", {28'b0, out_keep}, 32'h1);
    idle(1'b1);

    // Downstream stalled: first word must hold and block further input.
    w0 = words_out;
    for (int b = 1; b <= 4; b++) send(8'(b), 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h05, 1'b0, 1'b0, f);
      check("w33_hold", out_data, 32'h04030201);
      check("w33_rdy0", {31'b0, in_ready}, 32'd0);
    end
    for (int b = 5; b <= 8; b++) send(8'(b), 0, 1);
    check("w33_second", out_data, 32'h08070605);
    idle(1'b1);
    check("w33_count", words_out - w0, 32'd2);

    // Twelve bytes continuous: three words, ready held high throughout.
    w0 = words_out;
    for (int b = 0; b < 12; b++) begin
      step(1'b1, 8'(8'h20 + b), 1'b0, 1'b1, f);
      check("w34_accept", {31'b0, f}, 32'd1);
    end
    idle(1'b1);
    check("w34_count", words_out - w0, 32'd3);

    // Reset mid-packet discards the partial word.
    send(8'hE1, 0, 1); send(8'hE2, 0, 1);
    rst_n = 1'b0;
    idle(1'b1); idle(1'b1);
    rst_n = 1'b1;
    send(8'h55, 1, 1);
    check("w35_data", out_data, 32'h00000055);
    check("w35_keep", {28'b0, out_keep}, 32'h1);
    idle(1'b1);

    // Single byte with toggling ready transfers exactly once.
    w0 = words_out;
    send(8'h7E, 1, 0);
    for (int k = 0; k < 8; k++) idle(k[0]);
    check("w36_count", words_out - w0, 32'd1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 9) < 7), f);
    end
    rst_n = 1'b1;
    repeat (4) idle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv_byte_packer.md
RV_BYTE_PACKER -- requirements
Module: rv_byte_packer

Interface
REQ-001 Parameter: DATA_WIDTH, 8, width of one input byte lane.
REQ-002 Parameter: LANES, 4, byte lanes packed per output word.
REQ-003 clock_port  in  1  single clock; all state updates on rising edge.
REQ-004 reset_port  in  1  synchronous, active-low reset.
REQ-005 input_port_data  in  DATA_WIDTH  byte from upstream delay line.
REQ-006 input_port_valid  in  1  upstream byte valid.
REQ-007 input_port_last  in  1  byte is final of packet; qualified by input_port_valid.
REQ-008 input_port_ready  out  1  packer accepts byte this cycle.
REQ-009 output_port_data  out  DATA_WIDTH*LANES  packed word; lane 0 = bits [7:0].
REQ-010 output_port_keep  out  LANES  per-lane valid mask.
REQ-011 output_port_last  out  1  word closes packet.
REQ-012 output_port_valid  out  1  word valid.
REQ-013 output_port_ready  in  1  downstream accepts word.

Function
REQ-014 Byte transfer SHALL occur when input_port_valid & input_port_ready; word transfer when output_port_valid & output_port_ready.
REQ-015 Bytes SHALL fill lanes in arrival order, lane index = fill counter (0..LANES-1).
REQ-016 A word SHALL complete on accepting a byte with fill counter = LANES-1 or with input_port_last = 1.
REQ-017 input_port_ready SHALL be ~output_port_valid | output_port_ready when reset_port = 1; independent of input_port_valid, input_port_last and data.
REQ-018 On completion, output register SHALL load packed word, keep = lanes filled (incl. completing byte), last = input_port_last; output_port_valid rises next cycle (latency 1 cycle from completing byte).
REQ-019 Unfilled lanes of a partial word SHALL be driven 0 with keep bit 0.
REQ-020 On completion, fill counter SHALL return to 0 and accumulator lanes clear same edge; no byte dropped or duplicated.
REQ-021 Output word SHALL hold data/keep/last stable while output_port_valid & ~output_port_ready.
REQ-022 Simultaneous word transfer and completion SHALL load new word, output_port_valid stays 1 (no bubble).
REQ-023 Word transfer with no completion SHALL clear output_port_valid next cycle.
REQ-024 Sustained throughput SHALL be one byte per cycle while output_port_ready = 1.
REQ-025 Fill counter SHALL wrap LANES-1 -> 0; never exceed LANES-1.
REQ-026 Non-completing bytes SHALL be accepted only under REQ-017 (uniform ready rule).

Reset
REQ-027 While reset_port = 0: output_port_valid = 0, output_port_data = 0, output_port_keep = 0, output_port_last = 0, fill counter = 0, accumulator = 0, input_port_ready = 0.
REQ-028 Reset mid-packet SHALL discard partial word and any unconsumed output word; first byte after reset goes to lane 0.

Structure
REQ-029 Shared package rv_pack_pkg SHALL hold DATA_WIDTH, LANES defaults, keep-mask type, fill-counter type.
REQ-030 Single module; no sub-module; output register integral to packer.

Verification
REQ-031 Bytes 0x11,0x22,0x33,0x44 back-to-back, last on 0x44, ready=1 -> one word 0x44332211, keep 4'b1111, last 1, valid 1 cycle after 0x44.
REQ-032 Bytes 0xAA,0xBB, last on 0xBB -> word 0x0000BBAA, keep 4'b0011, last 1; next byte 0xCC lands lane 0.
REQ-033 Eight bytes 0x01..0x08, output_port_ready held 0 -> first word 0x04030201 holds stable, input_port_ready 0 after completion; release ready -> 0x08070605 follows, no loss.
REQ-034 Continuous 12 bytes, ready=1 -> 3 words on consecutive 4-cycle intervals, input_port_ready never 0.
REQ-035 reset_port=0 after 2 bytes of packet -> valid/keep/last/data 0, input_port_ready 0; after release 0x55 last -> word 0x00000055 keep 4'b0001.
REQ-036 Single byte 0x7E with last, ready toggling 0/1 -> word 0x0000007E, keep 4'b0001 transferred exactly once.
